// File: rtl/tetris_board_render_pkg.sv
// Shared colours, flash FSM state type and width helper for the Tetris playfield renderer.
package tetris_board_render_pkg;

    localparam logic [15:0] BLACK = 16'h0000;
    localparam logic [15:0] WHITE = 16'hFFFF;
    localparam logic [15:0] CYAN  = 16'h07FF;
    localparam logic [15:0] GREY  = 16'h8410;

    typedef enum logic {
        IDLE  = 1'b0,
        FLASH = 1'b1
    } flash_state_t;

    // Smallest r with 2**r >= v; returns 0 for v <= 1.
    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/tetris_flash_ctrl.sv
// Line-clear flash sequencer: counts frames while a flash runs and toggles the flash phase.
// Latency: state changes register on the clk edge that samples flash_start / frame_begin.
// Backpressure: none; flash_start while busy is dropped.
module tetris_flash_ctrl
    import tetris_board_render_pkg::*;
#(
    parameter int ROWS         = 20,
    parameter int FLASH_FRAMES = 6,
    parameter int FLASH_PERIOD = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            frame_begin,
    input  logic            flash_start,
    input  logic [ROWS-1:0] clear_rows,
    output logic            flash_busy,
    output logic            flash_done,
    output logic            flash_phase,
    output logic [ROWS-1:0] flash_rows
);

    localparam int FW = clog2(FLASH_FRAMES + 1);
    localparam int PW = clog2(FLASH_PERIOD + 1);

    flash_state_t   state;
    logic [FW-1:0]  frame_cnt;
    logic [PW-1:0]  period_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            frame_cnt   <= '0;
            period_cnt  <= '0;
            flash_busy  <= 1'b0;
            flash_done  <= 1'b0;
            flash_phase <= 1'b0;
            flash_rows  <= '0;
        end else begin
            flash_done <= 1'b0;
            case (state)
                IDLE: begin
                    // A coincident frame_begin is deliberately not counted here.
                    if (flash_start) begin
                        state       <= FLASH;
                        flash_rows  <= clear_rows;
                        flash_phase <= 1'b1;
                        frame_cnt   <= '0;
                        period_cnt  <= '0;
                        flash_busy  <= 1'b1;
                    end
                end
                FLASH: begin
                    if (frame_begin) begin
                        if (frame_cnt == FW'(FLASH_FRAMES - 1)) begin
                            state       <= IDLE;
                            frame_cnt   <= '0;
                            period_cnt  <= '0;
                            flash_busy  <= 1'b0;
                            flash_phase <= 1'b0;
                            flash_done  <= 1'b1;
                        end else begin
                            frame_cnt <= frame_cnt + 1'b1;
                            if (period_cnt == PW'(FLASH_PERIOD - 1)) begin
                                period_cnt  <= '0;
                                flash_phase <= ~flash_phase;
                            end else begin
                                period_cnt <= period_cnt + 1'b1;
                            end
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: rtl/tetris_board_render.sv
// Rotated Tetris playfield renderer: pixel_index -> RGB565 with frame snapshots, piece colour, border, line flash.
// Latency: fixed 2 cycles from pixel_index to oled_data, one pixel per cycle.
// Backpressure: none; the pipeline never stalls.
module tetris_board_render
    import tetris_board_render_pkg::*;
#(
    parameter int COLS         = 10,
    parameter int ROWS         = 20,
    parameter int CELL         = 4,
    parameter int SCR_W        = 96,
    parameter int SCR_H        = 64,
    parameter int X0           = 16,
    parameter int Y0           = 24,
    parameter int FLASH_FRAMES = 6,
    parameter int FLASH_PERIOD = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [12:0]          pixel_index,
    input  logic                 frame_begin,
    input  logic [COLS*ROWS-1:0] board,
    input  logic [COLS*ROWS-1:0] piece_mask,
    input  logic [ROWS-1:0]      clear_rows,
    input  logic                 flash_start,
    output logic [15:0]          oled_data,
    output logic                 flash_busy,
    output logic                 flash_done
);

    localparam int LOG2C = clog2(CELL);
    localparam int RW    = clog2(ROWS);
    localparam int CW    = clog2(COLS);
    localparam int IW    = clog2(COLS * ROWS);
    localparam int NPIX  = SCR_W * SCR_H;

    if ((CELL < 1) || ((CELL & (CELL - 1)) != 0)) begin : g_cell_check
        $error("tetris_board_render: CELL must be a power of two");
    end

    logic [COLS*ROWS-1:0] board_snap;
    logic [COLS*ROWS-1:0] piece_snap;
    logic                 flash_phase;
    logic [ROWS-1:0]      flash_rows;

    tetris_flash_ctrl #(
        .ROWS         (ROWS),
        .FLASH_FRAMES (FLASH_FRAMES),
        .FLASH_PERIOD (FLASH_PERIOD)
    ) u_flash_ctrl (
        .clk         (clk),
        .rst_n       (rst_n),
        .frame_begin (frame_begin),
        .flash_start (flash_start),
        .clear_rows  (clear_rows),
        .flash_busy  (flash_busy),
        .flash_done  (flash_done),
        .flash_phase (flash_phase),
        .flash_rows  (flash_rows)
    );

    logic [12:0]   px_x, px_y, fx, fy;
    logic          px_valid, in_field_c, on_border_c;
    logic [RW-1:0] row_c;
    logic [CW-1:0] col_c;

    // Board rows run along screen x (row ROWS-1 at X0), columns along screen y.
    always_comb begin
        px_valid    = pixel_index < 13'(NPIX);
        px_x        = pixel_index % 13'(SCR_W);
        px_y        = pixel_index / 13'(SCR_W);
        fx          = px_x - 13'(X0);
        fy          = px_y - 13'(Y0);
        in_field_c  = px_valid
                   && (px_x >= 13'(X0)) && (px_x < 13'(X0 + ROWS * CELL))
                   && (px_y >= 13'(Y0)) && (px_y < 13'(Y0 + COLS * CELL));
        on_border_c = px_valid
                   && (((px_x == 13'(X0 - 1)) && (px_y >= 13'(Y0 - 1)) && (px_y <= 13'(Y0 + COLS * CELL)))
                    || ((px_y == 13'(Y0 - 1)) && (px_x >= 13'(X0 - 1)) && (px_x <= 13'(X0 + ROWS * CELL))));
        row_c       = '0;
        col_c       = '0;
        if (in_field_c) begin
            row_c = RW'(13'(ROWS - 1) - (fx >> LOG2C));
            col_c = CW'(13'(COLS - 1) - (fy >> LOG2C));
        end
    end

    logic          in_field_q, on_border_q;
    logic [RW-1:0] row_q;
    logic [CW-1:0] col_q;
    logic [IW-1:0] cell_idx;
    logic          piece_hit, board_hit, row_flash;
    logic [15:0]   pix_colour;

    always_comb begin
        cell_idx  = IW'(row_q) * IW'(COLS) + IW'(col_q);
        piece_hit = in_field_q & piece_snap[cell_idx];
        board_hit = in_field_q & board_snap[cell_idx];
        row_flash = in_field_q & flash_phase & flash_rows[row_q];
        if (piece_hit) begin
            pix_colour = CYAN;
        end else if (board_hit) begin
            pix_colour = row_flash ? BLACK : WHITE;
        end else if (row_flash) begin
            pix_colour = WHITE;
        end else if (on_border_q) begin
            pix_colour = GREY;
        end else begin
            pix_colour = BLACK;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            board_snap  <= '0;
            piece_snap  <= '0;
            in_field_q  <= 1'b0;
            on_border_q <= 1'b0;
            row_q       <= '0;
            col_q       <= '0;
            oled_data   <= BLACK;
        end else begin
            if (frame_begin) begin
                board_snap <= board;
                piece_snap <= piece_mask;
            end
            in_field_q  <= in_field_c;
            on_border_q <= on_border_c;
            row_q       <= row_c;
            col_q       <= col_c;
            oled_data   <= pix_colour;
        end
    end

endmodule

// File: tb/tb_tetris_board_render.sv
// Bench for tetris_board_render: directed vector table, flash sequences and model-checked random frames.
module tb_tetris_board_render;

    localparam int COLS = 10, ROWS = 20, CELL = 4, SCR_W = 96, SCR_H = 64;
    localparam int X0 = 16, Y0 = 24, FLASH_FRAMES = 6, FLASH_PERIOD = 1;
    localparam logic [15:0] C_BLACK = 16'h0000, C_WHITE = 16'hFFFF;
    localparam logic [15:0] C_CYAN  = 16'h07FF, C_GREY  = 16'h8410;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic [12:0]          pixel_index;
    logic                 frame_begin;
    logic [COLS*ROWS-1:0] board, piece_mask;
    logic [ROWS-1:0]      clear_rows;
    logic                 flash_start;
    logic [15:0]          oled_data;
    logic                 flash_busy, flash_done;

    tetris_board_render dut (
        .clk(clk), .rst_n(rst_n), .pixel_index(pixel_index), .frame_begin(frame_begin),
        .board(board), .piece_mask(piece_mask), .clear_rows(clear_rows),
        .flash_start(flash_start), .oled_data(oled_data),
        .flash_busy(flash_busy), .flash_done(flash_done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model state: what the renderer should have latched / be flashing.
    logic [COLS*ROWS-1:0] m_board = '0, m_piece = '0;
    logic [ROWS-1:0]      m_rows = '0;
    bit                   m_busy = 0, m_phase = 0;
    int                   m_frames = 0;

    logic [12:0] q_idx[$];
    logic [15:0] q_exp[$];

    typedef struct {
        logic [12:0] idx;
        logic [15:0] exp;
    } vec_t;
    vec_t tbl[14];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string nm, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", nm, got, exp);
        end
    endtask

    function automatic logic [COLS*ROWS-1:0] rand_cells();
        logic [255:0] t;
        for (int i = 0; i < 8; i++) t[i*32 +: 32] = $urandom();
        return t[COLS*ROWS-1:0];
    endfunction

    function automatic logic [15:0] ref_pixel(input int idx);
        int x, y, r, c, b;
        bit infield, border, flashing;
        if (idx >= SCR_W * SCR_H) return C_BLACK;
        x = idx % SCR_W;
        y = idx / SCR_W;
        infield = (x >= X0) && (x < X0 + ROWS * CELL) && (y >= Y0) && (y < Y0 + COLS * CELL);
        border  = ((x == X0 - 1) && (y >= Y0 - 1) && (y <= Y0 + COLS * CELL))
               || ((y == Y0 - 1) && (x >= X0 - 1) && (x <= X0 + ROWS * CELL));
        if (infield) begin
            r = ROWS - 1 - (x - X0) / CELL;
            c = COLS - 1 - (y - Y0) / CELL;
            b = r * COLS + c;
            flashing = m_rows[r] && m_phase;
            if (m_piece[b]) return C_CYAN;
            if (m_board[b]) return flashing ? C_BLACK : C_WHITE;
            if (flashing) return C_WHITE;
        end
        return border ? C_GREY : C_BLACK;
    endfunction

    function automatic bit model_frame();
        bit done = 0;
        if (m_busy) begin
            m_frames++;
            if (m_frames == FLASH_FRAMES) begin
                m_busy = 0; m_phase = 0; done = 1;
            end else begin
                m_phase = ((m_frames / FLASH_PERIOD) % 2) == 0;
            end
        end
        return done;
    endfunction

    // Drive queued pixels back-to-back; each result is due two edges after its index.
    task automatic stream(input string nm, input bit jitter);
        int n = q_idx.size();
        for (int i = 0; i <= n; i++) begin
            if (i < n) pixel_index = q_idx[i];
            if (jitter) begin
                board = rand_cells();
                piece_mask = rand_cells();
            end
            tick();
            if (i >= 1) check($sformatf("%s[%0d]", nm, i - 1), oled_data, q_exp[i-1]);
        end
        q_idx.delete();
        q_exp.delete();
    endtask

    task automatic one_pixel(input string nm, input logic [12:0] idx, input logic [15:0] exp);
        q_idx.push_back(idx);
        q_exp.push_back(exp);
        stream(nm, 0);
    endtask

    task automatic pulse_frame();
        bit exp_done;
        frame_begin = 1;
        m_board = board;
        m_piece = piece_mask;
        exp_done = model_frame();
        tick();
        frame_begin = 0;
        check("frame_flash_done", {15'd0, flash_done}, {15'd0, exp_done});
        check("frame_flash_busy", {15'd0, flash_busy}, {15'd0, m_busy});
    endtask

    task automatic start_flash(input logic [ROWS-1:0] rows, input bit with_frame);
        bit exp_done = 0;
        clear_rows = rows;
        flash_start = 1;
        frame_begin = with_frame;
        if (with_frame) begin
            m_board = board;
            m_piece = piece_mask;
        end
        if (!m_busy) begin
            m_busy = 1; m_rows = rows; m_frames = 0; m_phase = 1;
        end else if (with_frame) begin
            exp_done = model_frame();
        end
        tick();
        flash_start = 0;
        frame_begin = 0;
        check("start_flash_busy", {15'd0, flash_busy}, {15'd0, m_busy});
        check("start_flash_done", {15'd0, flash_done}, {15'd0, exp_done});
    endtask

    function automatic logic [12:0] rand_index();
        int mode = $urandom_range(0, 9);
        if (mode < 6) return 13'($urandom_range(0, SCR_W * SCR_H - 1));
        if (mode == 6) return 13'($urandom_range(SCR_W * SCR_H, 8191));
        if (mode == 7) return 13'($urandom_range(0, SCR_H - 1) * SCR_W + X0 - 1);
        if (mode == 8) return 13'((Y0 - 1) * SCR_W + $urandom_range(0, SCR_W - 1));
        return 13'($urandom_range(X0 - 2, X0 + 1) + SCR_W * $urandom_range(Y0 - 2, SCR_H - 1));
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 0; pixel_index = 13'd5852; frame_begin = 0;
        board = '0; piece_mask = '0; clear_rows = '0; flash_start = 0;

        // Reset state.
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rst_busy", {15'd0, flash_busy}, 16'd0);
            check("rst_done", {15'd0, flash_done}, 16'd0);
            check("rst_oled", oled_data, C_BLACK);
        end
        rst_n = 1;
        board = '1;
        one_pixel("empty_before_frame", 13'd5852, C_BLACK);

        // Directed table against a fixed snapshot.
        tbl[0]  = '{13'd5852, C_WHITE};  tbl[1]  = '{13'd5851, C_BLACK};
        tbl[2]  = '{13'd2320, C_CYAN};   tbl[3]  = '{13'd2895, C_GREY};
        tbl[4]  = '{13'd6144, C_BLACK};  tbl[5]  = '{13'd6143, C_WHITE};
        tbl[6]  = '{13'd2222, C_BLACK};  tbl[7]  = '{13'd2223, C_GREY};
        tbl[8]  = '{13'd2228, C_GREY};   tbl[9]  = '{13'd2318, C_BLACK};
        tbl[10] = '{13'd2319, C_GREY};   tbl[11] = '{13'd2207, C_BLACK};
        tbl[12] = '{13'd3000, C_BLACK};  tbl[13] = '{13'd8191, C_BLACK};
        board = '0; board[0] = 1; board[199] = 1;
        piece_mask = '0; piece_mask[199] = 1;
        pulse_frame();
        for (int i = 0; i < 14; i++) begin
            q_idx.push_back(tbl[i].idx);
            q_exp.push_back(tbl[i].exp);
        end
        stream("table", 0);

        // Snapshot isolation: input changes are invisible until the next frame_begin.
        board = '0; piece_mask = '0;
        one_pixel("iso_hold_board", 13'd5852, C_WHITE);
        one_pixel("iso_hold_piece", 13'd2320, C_CYAN);
        pulse_frame();
        one_pixel("iso_new_board", 13'd5852, C_BLACK);
        one_pixel("iso_new_piece", 13'd2320, C_BLACK);

        // Flash of row 0, with a second start mid-sequence that must be ignored.
        board = '0; board[COLS-1:0] = '1;
        pulse_frame();
        start_flash(20'd1, 0);
        for (int k = 1; k <= 6; k++) begin
            if (k == 3) start_flash(20'd0, 0);
            one_pixel($sformatf("flash_frame%0d", k), 13'd5852, (k % 2 == 1) ? C_BLACK : C_WHITE);
            one_pixel($sformatf("flash_row1_%0d", k), 13'd5851, C_BLACK);
            pulse_frame();
        end
        tick();
        check("flash_done_one_cycle", {15'd0, flash_done}, 16'd0);
        one_pixel("flash_after", 13'd5852, C_WHITE);

        // Start coincident with frame_begin, clear_rows = 0: frame not counted, no visible effect.
        start_flash(20'd0, 1);
        one_pixel("flash_norows", 13'd5852, C_WHITE);
        for (int k = 1; k <= 6; k++) pulse_frame();

        // Random frames, random flashes, inputs jittered mid-frame.
        for (int r = 0; r < 14; r++) begin
            if ($urandom_range(0, 2) == 0) start_flash(20'($urandom()), $urandom_range(0, 1) == 1);
            board = rand_cells();
            piece_mask = rand_cells() & rand_cells() & rand_cells();
            pulse_frame();
            for (int i = 0; i < 40; i++) begin
                q_idx.push_back(rand_index());
                q_exp.push_back(ref_pixel(int'(q_idx[i])));
            end
            stream($sformatf("rand%0d", r), 1);
        end
        while (m_busy) pulse_frame();

        // Reset during frame 3 of a flash.
        board = '0; board[COLS-1:0] = '1; piece_mask = '0;
        pulse_frame();
        start_flash(20'd1, 0);
        pulse_frame();
        pulse_frame();
        rst_n = 0;
        tick();
        check("midrst_busy", {15'd0, flash_busy}, 16'd0);
        check("midrst_done", {15'd0, flash_done}, 16'd0);
        tick();
        rst_n = 1;
        for (int i = 0; i < 8; i++) begin
            tick();
            check("midrst_no_done", {15'd0, flash_done}, 16'd0);
            check("midrst_no_busy", {15'd0, flash_busy}, 16'd0);
        end
        one_pixel("midrst_pixel", 13'd5852, C_BLACK);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/tetris_board_render.md
Name: tetris_board_render

Overview:
- Pipelined, parametrised renderer that turns an OLED pixel_index into a 16-bit RGB565 pixel for the Tetris playfield.
- The board is drawn rotated: board rows run along screen x, board columns along screen y.
- Adds four things over the fixed 10x20 combinational mapper:
  - per-frame snapshot of board and active-piece state, so frames do not tear;
  - a separate active-piece colour;
  - a playfield border;
  - a frame-counted line-clear flash sequencer.
- Sits between the Tetris game core and the OLED driver, clocked by the OLED pixel clock.

Parameters:
- COLS, 10, board columns.
- ROWS, 20, board rows.
- CELL, 4, cell edge in pixels; must be a power of two (elaboration error otherwise).
- SCR_W, 96, screen width in pixels.
- SCR_H, 64, screen height in pixels.
- X0, 16, screen x of the left edge of board row ROWS-1.
- Y0, 24, screen y of the top edge of board column COLS-1.
- FLASH_FRAMES, 6, number of frames a line-clear flash lasts.
- FLASH_PERIOD, 1, frames per flash phase toggle.

Ports:
- clk  in  1  pixel clock.
- rst_n  in  1  synchronous, active-low reset.
- pixel_index  in  13  linear pixel address; x = index % SCR_W, y = index / SCR_W.
- frame_begin  in  1  one-cycle pulse at start of frame.
- board  in  COLS*ROWS  settled cells, row-major; bit r*COLS+c is row r, column c.
- piece_mask  in  COLS*ROWS  active falling piece, same indexing as board.
- clear_rows  in  ROWS  rows to flash; sampled on flash_start.
- flash_start  in  1  one-cycle request to begin a flash.
- oled_data  out  16  pixel colour, RGB565.
- flash_busy  out  1  high while a flash sequence runs.
- flash_done  out  1  one-cycle pulse when a flash completes.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - oled_data = BLACK, flash_busy = 0, flash_done = 0.
  - Board and piece snapshots cleared to 0; flash phase = 0; frame counter = 0.
  - Reset mid-flash aborts the flash with no flash_done.
- Snapshot:
  - On frame_begin, board and piece_mask are latched.
  - Pixels presented on the cycle after frame_begin use the new snapshot.
  - Until the first frame_begin after reset, the field renders empty (border only).
- Pipeline, fixed latency of 2 cycles from pixel_index to oled_data, one pixel per cycle, no stalls:
  - Stage 1 registers x, y, an in_field flag, an on_border flag and cell coordinates.
  - Field region: X0 <= x < X0+ROWS*CELL and Y0 <= y < Y0+COLS*CELL.
  - Cell coordinates: row = ROWS-1-((x-X0)>>log2 CELL), col = COLS-1-((y-Y0)>>log2 CELL).
  - Stage 2 indexes the snapshots and registers the colour.
- Colour priority, highest first:
  - piece bit set -> CYAN.
  - board bit set -> WHITE; if the row is flashing and phase = 1 -> BLACK.
  - board bit clear in a flashing row with phase = 1 -> WHITE.
  - on_border -> GREY.
  - otherwise BLACK.
- Border:
  - Drawn on x = X0-1 for Y0-1 <= y <= Y0+COLS*CELL.
  - Drawn on y = Y0-1 for X0-1 <= x <= X0+ROWS*CELL.
  - Coordinates outside the screen are simply never generated.
- pixel_index >= SCR_W*SCR_H -> BLACK.
- Flash FSM:
  - States: IDLE, FLASH.
  - IDLE -> FLASH on flash_start: latch clear_rows, phase = 1, counter = 0, flash_busy = 1.
  - In FLASH, each frame_begin increments the counter; phase toggles every FLASH_PERIOD frames.
  - When the counter reaches FLASH_FRAMES, go to IDLE: flash_busy = 0, phase = 0, flash_done high for exactly 1 cycle.
  - flash_start while busy is ignored.
  - flash_start and frame_begin in the same cycle: the flash starts and that frame_begin is not counted.
  - clear_rows = 0 still runs the full sequence with no visible effect.

Decomposition:
- Add colour constants CYAN = 16'h07FF and GREY = 16'h8410 to definitions.vh, alongside the existing WHITE and BLACK.
- Add a clog2 helper macro to the same header.
- One natural sub-module: tetris_flash_ctrl, containing the flash FSM, frame counter and phase.
- The pixel pipeline stays in the top module.

Test Plan:
- Reset, then pixel_index = 5852 (x=92, y=60) with no frame_begin -> oled_data = 16'h0000 two cycles later. Throughout reset, flash_busy = 0.
- board bit 0 set, pulse frame_begin. Then pixel_index 5852 -> WHITE at +2 cycles; 5851 (x=91, row 1) -> BLACK; back-to-back indices produce back-to-back outputs.
- piece_mask bit 199 and board bit 199 set, frame_begin, pixel_index 2320 (x=16, y=24) -> CYAN. pixel_index 2895 (x=15, y=30) -> GREY. pixel_index 6144 -> BLACK.
- Snapshot isolation: after a frame_begin, change board mid-frame -> output unchanged until the next frame_begin.
- Flash: board row 0 full, clear_rows = 1, flash_start. Pixel 5852 then shows, across six successive frame_begins: BLACK, WHITE, BLACK, WHITE, BLACK, WHITE. flash_done pulses once on the 6th; flash_busy falls the same cycle. A second flash_start issued mid-sequence is ignored.
- Assert rst_n = 0 during frame 3 of a flash -> flash_busy = 0, no flash_done, and pixel 5852 renders BLACK (snapshot cleared).
